// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Channel index splits into s1 = ch[2:0] and s0 = ch[3].
package mux_scan_pkg;

   localparam int NUM_CH = 16;
   localparam int CH_W   = 4;
   localparam int S1_W   = 3;
   localparam int S0_BIT = 3;
   localparam int DW_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } scan_st_e;

endpackage

// File: rtl/mux_scan_if.sv
// Sample stream from the scan sequencer.
// Carries {channel, data} with a valid/ready handshake.
interface mux_scan_if
   import mux_scan_pkg::*;
#(
   parameter int DATA_W = 4
) ();

   logic              out_valid;
   logic              out_ready;
   logic [CH_W-1:0]   out_ch;
   logic [DATA_W-1:0] out_data;

   modport master (
      output out_valid,
      output out_ch,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_ch,
      input  out_data,
      output out_ready
   );

endinterface

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest enabled channel strictly above cur.
// found=0 when no such channel exists.
module mux_scan_next_ch
   import mux_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [CH_W-1:0]   cur_i,
   output logic [CH_W-1:0]   next_o,
   output logic              found_o
);

   always_comb begin
      next_o  = '0;
      found_o = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found_o && mask_i[i] && (i > int'(cur_i))) begin
            next_o  = CH_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Masked round-robin scan of a 16:1 mux: select, settle,
// sample y and emit {channel, data} on a valid/ready stream.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DWELL  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              cont_i,
   input  logic [NUM_CH-1:0] ch_mask_i,
   output logic [S1_W-1:0]   sel_s1_o,
   output logic              sel_s0_o,
   input  logic [DATA_W-1:0] mux_y_i,
   output logic              busy_o,
   output logic              done_o,
   mux_scan_if.master        out_if
);

   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

   scan_st_e          state_q;
   logic [CH_W-1:0]   ch_q;
   logic [DW_W-1:0]   dwell_q;
   logic [NUM_CH-1:0] mask_q;
   logic              cont_q;
   logic              valid_q;
   logic [CH_W-1:0]   och_q;
   logic [DATA_W-1:0] data_q;
   logic              done_q;

   logic [NUM_CH-1:0] mask_sel;
   logic [CH_W-1:0]   nxt_ch;
   logic              nxt_found;
   logic [CH_W-1:0]   low_ch;
   logic              low_found;
   logic [CH_W-1:0]   first_ch;

   // In IDLE the live mask is about to be latched, so look at it directly
   assign mask_sel = (state_q == ST_IDLE) ? ch_mask_i : mask_q;

   mux_scan_next_ch u_next (
      .mask_i  (mask_q),
      .cur_i   (ch_q),
      .next_o  (nxt_ch),
      .found_o (nxt_found)
   );

   mux_scan_next_ch u_first (
      .mask_i  (mask_sel),
      .cur_i   ('0),
      .next_o  (low_ch),
      .found_o (low_found)
   );

   assign first_ch = (mask_sel[0] || !low_found) ? '0 : low_ch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         dwell_q <= '0;
         mask_q  <= '0;
         cont_q  <= 1'b0;
         valid_q <= 1'b0;
         och_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  mask_q <= ch_mask_i;
                  cont_q <= cont_i;
                  if (|ch_mask_i) begin
                     ch_q    <= first_ch;
                     dwell_q <= '0;
                     state_q <= ST_SETTLE;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (dwell_q == DW_LAST) begin
                  data_q  <= mux_y_i;
                  och_q   <= ch_q;
                  valid_q <= 1'b1;
                  state_q <= ST_HOLD;
               end else begin
                  dwell_q <= dwell_q + 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_if.out_ready) begin
                  valid_q <= 1'b0;
                  dwell_q <= '0;
                  if (nxt_found) begin
                     ch_q    <= nxt_ch;
                     state_q <= ST_SETTLE;
                  end else begin
                     done_q <= 1'b1;
                     if (cont_q) begin
                        ch_q    <= first_ch;
                        state_q <= ST_SETTLE;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sel_s1_o        = ch_q[S1_W-1:0];
   assign sel_s0_o        = ch_q[S0_BIT];
   assign busy_o          = (state_q != ST_IDLE);
   assign done_o          = done_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_ch    = och_q;
   assign out_if.out_data  = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (DWELL=1 and DWELL=4).
module tb_mux_scan_sequencer;
   import mux_scan_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start1 = 1'b0, cont1 = 1'b0;
   logic [15:0] mask1 = '0;
   logic [2:0]  s1_1;
   logic        s0_1, busy1, done1;
   logic [3:0]  y1;
   mux_scan_if #(.DATA_W(4)) if1 ();

   logic        start4 = 1'b0, cont4 = 1'b0;
   logic [15:0] mask4 = '0;
   logic [2:0]  s1_4;
   logic        s0_4, busy4, done4;
   logic [3:0]  y4 = 4'h3;
   mux_scan_if #(.DATA_W(4)) if4 ();

   // mux model: input c carries value c
   assign y1 = {s0_1, s1_1};

   mux_scan_sequencer #(.DATA_W(4), .DWELL(1)) u1 (
      .clk(clk), .rst(rst), .start_i(start1), .cont_i(cont1),
      .ch_mask_i(mask1), .sel_s1_o(s1_1), .sel_s0_o(s0_1),
      .mux_y_i(y1), .busy_o(busy1), .done_o(done1), .out_if(if1)
   );

   mux_scan_sequencer #(.DATA_W(4), .DWELL(4)) u4 (
      .clk(clk), .rst(rst), .start_i(start4), .cont_i(cont4),
      .ch_mask_i(mask4), .sel_s1_o(s1_4), .sel_s0_o(s0_4),
      .mux_y_i(y4), .busy_o(busy4), .done_o(done4), .out_if(if4)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int beats, dones, done_at, expch;
      logic pv, pr;
      logic [3:0] pch, pdata, psel;

      if1.out_ready = 1'b0;
      if4.out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", 32'(if1.out_valid), 0);
      chk("rst_ch", 32'(if1.out_ch), 0);
      chk("rst_data", 32'(if1.out_data), 0);
      chk("rst_sel", 32'({s0_1, s1_1}), 0);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);

      // reset while holding channel 5
      mask1 = 16'h0020; start1 = 1'b1;
      step();
      start1 = 1'b0;
      step();
      chk("mid_valid", 32'(if1.out_valid), 1);
      chk("mid_ch", 32'(if1.out_ch), 5);
      chk("mid_data", 32'(if1.out_data), 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(if1.out_valid), 0);
      chk("mid_rst_ch", 32'(if1.out_ch), 0);
      chk("mid_rst_data", 32'(if1.out_data), 0);
      chk("mid_rst_sel", 32'({s0_1, s1_1}), 0);
      chk("mid_rst_busy", 32'(busy1), 0);
      chk("mid_rst_done", 32'(done1), 0);
      mask1 = 16'h0002; if1.out_ready = 1'b1; start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("re_sel", 32'({s0_1, s1_1}), 1);
      chk("re_busy", 32'(busy1), 1);
      step();
      chk("re_valid", 32'(if1.out_valid), 1);
      chk("re_ch", 32'(if1.out_ch), 1);
      step();
      chk("re_done", 32'(done1), 1);
      chk("re_busy_end", 32'(busy1), 0);

      // full scan
      mask1 = 16'hFFFF; start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("A_sel0", 32'({s0_1, s1_1}), 0);
      chk("A_busy", 32'(busy1), 1);
      chk("A_novalid", 32'(if1.out_valid), 0);
      beats = 0; dones = 0; done_at = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (if1.out_valid) begin
            chk("A_ch", 32'(if1.out_ch), 32'(beats));
            chk("A_data", 32'(if1.out_data), 32'(beats));
            chk("A_sel", 32'({s0_1, s1_1}), 32'(beats));
            chk("A_s0", 32'(s0_1), 32'(beats >= 8));
            beats++;
         end
         if (done1) begin
            dones++;
            if (dones == 1) done_at = i + 1;
         end
      end
      chk("A_beats", 32'(beats), 16);
      chk("A_dones", 32'(dones), 1);
      chk("A_done_at", 32'(done_at), 32);
      chk("A_idle", 32'(busy1), 0);

      // two channels, ready one cycle in three
      mask1 = 16'h8001; if1.out_ready = 1'b0; start1 = 1'b1;
      step();
      start1 = 1'b0;
      beats = 0; dones = 0; pv = 1'b0; pr = 1'b0;
      pch = '0; pdata = '0; psel = '0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (if1.out_valid && pv && !pr) begin
            chk("B_ch_stable", 32'(if1.out_ch), 32'(pch));
            chk("B_data_stable", 32'(if1.out_data), 32'(pdata));
            chk("B_sel_stable", 32'({s0_1, s1_1}), 32'(psel));
         end
         if (done1) dones++;
         if1.out_ready = (i % 3 == 2);
         if (if1.out_valid && if1.out_ready) begin
            chk("B_ch", 32'(if1.out_ch), (beats == 0) ? 0 : 15);
            chk("B_data", 32'(if1.out_data), (beats == 0) ? 0 : 15);
            beats++;
         end
         pv = if1.out_valid; pr = if1.out_ready;
         pch = if1.out_ch; pdata = if1.out_data;
         psel = {s0_1, s1_1};
      end
      chk("B_beats", 32'(beats), 2);
      chk("B_dones", 32'(dones), 1);

      // empty mask
      if1.out_ready = 1'b1; mask1 = '0; start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("C_done", 32'(done1), 1);
      chk("C_busy", 32'(busy1), 0);
      chk("C_valid", 32'(if1.out_valid), 0);
      step();
      chk("C_done_pulse", 32'(done1), 0);
      chk("C_busy2", 32'(busy1), 0);
      chk("C_valid2", 32'(if1.out_valid), 0);

      // DWELL=4: y changes two cycles into the settle window
      mask4 = 16'h0020; y4 = 4'h3; start4 = 1'b1;
      step();
      start4 = 1'b0;
      chk("D_sel", 32'({s0_4, s1_4}), 5);
      step();
      step();
      y4 = 4'hA;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      chk("D_not_yet", 32'(if4.out_valid), 0);
      step();
      chk("D_valid", 32'(if4.out_valid), 1);
      chk("D_data", 32'(if4.out_data), 32'hA);
      chk("D_ch", 32'(if4.out_ch), 5);
      step();
      chk("D_done", 32'(done4), 1);
      chk("D_idle", 32'(busy4), 0);
      step();
      step();
      chk("D_no_restart", 32'(busy4), 0);
      chk("D_no_valid", 32'(if4.out_valid), 0);

      // continuous loop over channels 8 and 9
      mask1 = 16'h0300; cont1 = 1'b1; start1 = 1'b1;
      step();
      start1 = 1'b0;
      beats = 0; dones = 0; pch = '0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 6) begin
            mask1 = 16'hFFFF; cont1 = 1'b0; start1 = 1'b1;
         end else begin
            start1 = 1'b0;
         end
         if (if1.out_valid) begin
            expch = (beats % 2 == 0) ? 8 : 9;
            chk("E_ch", 32'(if1.out_ch), 32'(expch));
            chk("E_data", 32'(if1.out_data), 32'(expch));
            pch = if1.out_ch;
            beats++;
         end
         if (done1) begin
            chk("E_done_after9", 32'(pch), 9);
            dones++;
         end
      end
      start1 = 1'b0;
      chk("E_beats", 32'(beats), 10);
      chk("E_dones", 32'(dones), 5);
      chk("E_still_busy", 32'(busy1), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("E_rst_valid", 32'(if1.out_valid), 0);
      chk("E_rst_busy", 32'(busy1), 0);
      chk("E_rst_sel", 32'({s0_1, s1_1}), 0);
      step();
      step();
      chk("E_stopped_busy", 32'(busy1), 0);
      chk("E_stopped_valid", 32'(if1.out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
